pmem_responder: RTL and testbench
=================================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, legal range 1..15: cycles from request acceptance to pmem_resp.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8: log2 of the number of 128-bit blocks in the backing store.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pmem_read  input  1  block read request; held by the initiator until pmem_resp.
REQ-006 pmem_write  input  1  block write request; held by the initiator until pmem_resp.
REQ-007 pmem_address  input  16 (lc3b_word)  byte address; bits [3:0] ignored; block index = [INDEX_WIDTH+3:4].
REQ-008 pmem_wdata  input  128 (lc3b_c_block)  write block; word 0 in bits [15:0].
REQ-009 pmem_resp  output  1  one-cycle completion pulse.
REQ-010 pmem_rdata  output  128 (lc3b_c_block)  read block; valid in the pmem_resp cycle.
REQ-011 err  output  1  sticky protocol/range error flag.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-013 In IDLE, when pmem_read or pmem_write is high, the block SHALL capture address, wdata and op at that edge and move to BUSY (LATENCY>1) or RESP (LATENCY=1).
REQ-014 BUSY SHALL count LATENCY-1 cycles with a 4-bit down-counter, then move to RESP.
REQ-015 Latency: request first high in IDLE cycle 0 -> pmem_resp high in cycle LATENCY, for exactly one cycle.
REQ-016 RESP SHALL always go to IDLE on the next edge; a request high in that following IDLE cycle is a new transaction (back-to-back rate = LATENCY+1 cycles).
REQ-017 Read: pmem_rdata SHALL equal store[index] as of the capture edge, be driven in the RESP cycle, and hold until the next read's RESP.
REQ-018 Write: store[index] SHALL be updated with the captured wdata on the edge leaving RESP; pmem_rdata is unchanged by writes.
REQ-019 A read issued after a write to the same block SHALL return the new data.
REQ-020 pmem_read and pmem_write both high at acceptance: the operation SHALL be treated as a write, and err SHALL set.
REQ-021 Out-of-range address (bits [15:INDEX_WIDTH+4] nonzero): a read SHALL return all zeros, a write SHALL be dropped, err SHALL set, and pmem_resp SHALL still pulse at normal latency.
REQ-022 Inputs SHALL be ignored in BUSY and RESP; a request dropped mid-transaction still completes and pulses pmem_resp, with no err.
REQ-023 The store SHALL be a synchronous single-port block RAM (read at capture, write at RESP exit) with no initialisation beyond simulation zero-fill.

Reset
REQ-024 With reset high at an edge, the block SHALL reach IDLE, pmem_resp=0, pmem_rdata=0, err=0 and counter=0.
REQ-025 Reset during BUSY or RESP SHALL abort the transaction: no pmem_resp pulse, pending write discarded, store contents preserved.
REQ-026 Reset SHALL take priority over any request in the same cycle; requests are accepted from the first cycle after reset deasserts.

Verification
REQ-027 LATENCY=4: write 0x1111..._8888 (word n = 0x1111*(n+1)) at 0x0040 -> resp in cycle 4 only; read 0x004E -> resp in cycle 4 of the read, pmem_rdata = written block, err=0.
REQ-028 Back-to-back: hold the read at 0x0000 one cycle past resp -> second resp exactly 5 cycles after the first, same data; no extra pulses.
REQ-029 Read and write both high at 0x0100 with wdata=all 0xA5 -> treated as a write, err=1; a later read of 0x0100 returns all 0xA5.
REQ-030 INDEX_WIDTH=8: write to 0x1000 -> resp pulses, err=1; a read of 0x0000 is unchanged; a read of 0x1000 returns 0.
REQ-031 Reset asserted in the 2nd BUSY cycle of a write to 0x0080 -> no resp, IDLE next cycle; a subsequent read of 0x0080 returns the pre-write contents.
REQ-032 LATENCY=1 sweep: 16 random writes and reads checked against a scoreboard; pmem_resp is always high for exactly 1 cycle, one cycle after acceptance.

Source files
------------

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency 128-bit block memory responder.
//
// Accepts one block read or write at a time from IDLE, waits LATENCY cycles,
// then pulses pmem_resp for one cycle. The backing store is a single-port
// synchronous RAM: it is read on the accepting edge and written on the edge
// leaving RESP, so the two accesses never share a cycle.
//
// Parameters
//   LATENCY      cycles from request acceptance to pmem_resp (1..15)
//   INDEX_WIDTH  log2 of the number of 128-bit blocks in the store
// Ports
//   clk           clock, all state on the rising edge
//   reset         synchronous active-high reset
//   pmem_read     block read request, held until pmem_resp
//   pmem_write    block write request, held until pmem_resp
//   pmem_address  byte address; block index = [INDEX_WIDTH+3:4]
//   pmem_wdata    write block, word 0 in bits [15:0]
//   pmem_resp     one-cycle completion pulse
//   pmem_rdata    read block, valid in the pmem_resp cycle, held until next read
//   err           sticky flag: read+write together, or out-of-range address
module pmem_responder #(
  parameter int LATENCY     = 4,
  parameter int INDEX_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam int         DEPTH  = 2 ** INDEX_WIDTH;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   err_q;
  logic [127:0]           rdata_q;

  // Transaction captured at acceptance
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   write_q;
  logic                   oor_q;
  logic [127:0]           wdata_q;

  // Block RAM and its registered read port
  logic [127:0]           store [DEPTH];
  logic [127:0]           ram_rd_q;

  logic                   req;
  logic                   accept;
  logic                   ram_we;
  logic                   addr_oor;
  logic [INDEX_WIDTH-1:0] addr_idx;
  logic [127:0]           rd_val;
  logic                   unused_addr_bits;

  assign req      = pmem_read | pmem_write;
  assign accept   = (state_q == IDLE) && req && !reset;
  assign addr_idx = pmem_address[INDEX_WIDTH+3:4];
  assign unused_addr_bits = ^pmem_address[3:0];

  // Upper address bits above the index must be zero; with a full 12-bit
  // index every 16-bit address is in range.
  generate
    if (INDEX_WIDTH + 4 < 16) begin : g_range
      assign addr_oor = |pmem_address[15:INDEX_WIDTH+4];
    end else begin : g_no_range
      assign addr_oor = 1'b0;
    end
  endgenerate

  // Out-of-range reads return zeros instead of whatever the aliased RAM
  // location holds.
  assign rd_val = oor_q ? '0 : ram_rd_q;

  // Reset in RESP must discard the pending write.
  assign ram_we = (state_q == RESP) && write_q && !oor_q && !reset;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        // Counter enters at LATENCY-1; BUSY lasts exactly LATENCY-1 cycles.
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && ((pmem_read && pmem_write) || addr_oor)) begin
        err_q <= 1'b1;
      end
      // Latch the read result as the RESP cycle ends so it holds afterwards.
      if ((state_q == RESP) && !write_q) begin
        rdata_q <= rd_val;
      end
    end
  end

  // Capture registers; read+write together resolves to a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr_idx;
      write_q <= pmem_write;
      oor_q   <= addr_oor;
      wdata_q <= pmem_wdata;
    end
  end

  // Single-port RAM: read on accept, write on RESP exit.
  always_ff @(posedge clk) begin
    if (accept) begin
      ram_rd_q <= store[addr_idx];
    end
    if (ram_we) begin
      store[idx_q] <= wdata_q;
    end
  end

  assign pmem_resp  = (state_q == RESP);
  assign pmem_rdata = ((state_q == RESP) && !write_q) ? rd_val : rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1,
// both INDEX_WIDTH=8, checked against an associative-array memory model.
module tb_pmem_responder;

  logic         clk;
  logic         rst_s   [2];
  logic         rd_s    [2];
  logic         wr_s    [2];
  logic [15:0]  addr_s  [2];
  logic [127:0] wd_s    [2];
  logic         resp_o  [2];
  logic [127:0] rdata_o [2];
  logic         err_o   [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [127:0] mem [int];
  logic [127:0] last_rd [2];
  bit           err_exp [2];
  int           lat     [2];
  logic [15:0]  keys    [2][$];

  pmem_responder #(.LATENCY(4), .INDEX_WIDTH(8)) dut4 (
    .clk(clk), .reset(rst_s[0]), .pmem_read(rd_s[0]), .pmem_write(wr_s[0]),
    .pmem_address(addr_s[0]), .pmem_wdata(wd_s[0]), .pmem_resp(resp_o[0]),
    .pmem_rdata(rdata_o[0]), .err(err_o[0])
  );

  pmem_responder #(.LATENCY(1), .INDEX_WIDTH(8)) dut1 (
    .clk(clk), .reset(rst_s[1]), .pmem_read(rd_s[1]), .pmem_write(wr_s[1]),
    .pmem_address(addr_s[1]), .pmem_wdata(wd_s[1]), .pmem_resp(resp_o[1]),
    .pmem_rdata(rdata_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [15:0] a);
    return (a / 16'd4096) != 0;
  endfunction

  function automatic int key_of(input int u, input logic [15:0] a);
    return u * 4096 + ((int'(a) / 16) % 256);
  endfunction

  function automatic logic [127:0] rand_blk();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One complete transaction with latency, pulse width, data and err checks.
  task automatic txn(input int u, input bit r, input bit w,
                     input logic [15:0] a, input logic [127:0] d);
    int           c;
    bit           seen;
    logic [127:0] got;
    logic [127:0] exp_rd;
    int           k;
    k    = key_of(u, a);
    seen = 0;
    c    = 0;
    got  = '0;
    @(negedge clk);
    rd_s[u] = r; wr_s[u] = w; addr_s[u] = a; wd_s[u] = d;
    while (!seen && c < 40) begin
      if (resp_o[u]) begin
        seen = 1;
        got  = rdata_o[u];
      end else begin
        @(negedge clk);
        c++;
      end
    end
    rd_s[u] = 1'b0; wr_s[u] = 1'b0;
    if (!seen) check_eq("resp_timeout", 128'd0, 128'd1);
    else       check_eq("latency", 128'(c), 128'(lat[u]));
    if (w) begin
      if (!is_oor(a)) mem[k] = d;
      exp_rd = last_rd[u];
    end else begin
      exp_rd = is_oor(a) ? 128'd0 : mem[k];
      last_rd[u] = exp_rd;
    end
    check_eq("rdata", got, exp_rd);
    if ((r && w) || is_oor(a)) err_exp[u] = 1'b1;
    check_eq("err", 128'(err_o[u]), 128'(err_exp[u]));
    @(negedge clk);
    check_eq("pulse_width", 128'(resp_o[u]), 128'd0);
    $display("txn u=%0d rd=%0b wr=%0b addr=%h lat=%0d rdata=%h err=%0b",
             u, r, w, a, c, got, err_o[u]);
  endtask

  task automatic do_reset(input int u);
    @(negedge clk);
    rst_s[u] = 1'b1;
    @(negedge clk);
    check_eq("rst_resp", 128'(resp_o[u]), 128'd0);
    check_eq("rst_rdata", rdata_o[u], 128'd0);
    check_eq("rst_err", 128'(err_o[u]), 128'd0);
    rst_s[u]   = 1'b0;
    err_exp[u] = 1'b0;
    last_rd[u] = '0;
    $display("reset u=%0d", u);
  endtask

  task automatic rand_ops(input int u, input int n);
    logic [15:0]  a;
    logic [127:0] d;
    for (int i = 0; i < n; i++) begin
      a = keys[u][$urandom_range(keys[u].size() - 1)];
      a[3:0] = 4'($urandom);
      d = rand_blk();
      if ($urandom_range(1) == 1) txn(u, 1'b0, 1'b1, a, d);
      else                        txn(u, 1'b1, 1'b0, a, '0);
    end
  endtask

  initial begin
    logic [127:0] pat;
    logic [127:0] d1, d2;
    logic [15:0]  a;
    int           first_c, second_c, pulses;

    lat[0] = 4; lat[1] = 1;
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b1; rd_s[u] = 1'b0; wr_s[u] = 1'b0;
      addr_s[u] = '0; wd_s[u] = '0; last_rd[u] = '0; err_exp[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("init_resp", 128'(resp_o[u]), 128'd0);
      check_eq("init_rdata", rdata_o[u], 128'd0);
      check_eq("init_err", 128'(err_o[u]), 128'd0);
      rst_s[u] = 1'b0;
    end

    // Known contents for blocks read later
    txn(0, 1'b0, 1'b1, 16'h0000, rand_blk());
    txn(0, 1'b0, 1'b1, 16'h0080, rand_blk());

    // Counting-word pattern write then read at an offset within the block
    for (int n = 0; n < 8; n++) pat[16*n +: 16] = 16'(16'h1111 * (n + 1));
    txn(0, 1'b0, 1'b1, 16'h0040, pat);
    txn(0, 1'b1, 1'b0, 16'h004E, '0);
    check_eq("pattern_rd", last_rd[0], pat);

    // Back-to-back: read held one cycle past the first response
    @(negedge clk);
    rd_s[0] = 1'b1; addr_s[0] = 16'h0000;
    pulses = 0; first_c = -1; second_c = -1; d1 = '0; d2 = '0;
    for (int c = 0; c < 16; c++) begin
      if (resp_o[0]) begin
        pulses++;
        if (pulses == 1) begin first_c = c; d1 = rdata_o[0]; end
        if (pulses == 2) begin second_c = c; d2 = rdata_o[0]; rd_s[0] = 1'b0; end
      end
      @(negedge clk);
    end
    rd_s[0] = 1'b0;
    check_eq("b2b_pulses", 128'(pulses), 128'd2);
    check_eq("b2b_first", 128'(first_c), 128'd4);
    check_eq("b2b_gap", 128'(second_c - first_c), 128'd5);
    check_eq("b2b_d1", d1, mem[key_of(0, 16'h0000)]);
    check_eq("b2b_d2", d2, mem[key_of(0, 16'h0000)]);
    last_rd[0] = mem[key_of(0, 16'h0000)];
    $display("b2b pulses=%0d first=%0d second=%0d data=%h", pulses, first_c, second_c, d2);

    // Read and write together resolves to a write and flags err
    txn(0, 1'b1, 1'b1, 16'h0100, {16{8'hA5}});
    do_reset(0);
    txn(0, 1'b1, 1'b0, 16'h0100, '0);
    check_eq("both_rd", last_rd[0], {16{8'hA5}});

    // Out-of-range write dropped, read returns zero
    txn(0, 1'b0, 1'b1, 16'h1000, rand_blk());
    txn(0, 1'b1, 1'b0, 16'h0000, '0);
    txn(0, 1'b1, 1'b0, 16'h1000, '0);
    do_reset(0);

    // Reset in the second BUSY cycle of a write aborts it
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 16'h0080; wd_s[0] = rand_blk();
    pulses = 0;
    @(negedge clk);
    if (resp_o[0]) pulses++;
    @(negedge clk);
    if (resp_o[0]) pulses++;
    rst_s[0] = 1'b1; wr_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b0;
    check_eq("abort_rdata", rdata_o[0], 128'd0);
    for (int c = 0; c < 6; c++) begin
      if (resp_o[0]) pulses++;
      @(negedge clk);
    end
    check_eq("abort_pulses", 128'(pulses), 128'd0);
    err_exp[0] = 1'b0; last_rd[0] = '0;
    $display("abort pulses=%0d", pulses);
    txn(0, 1'b1, 1'b0, 16'h0080, '0);

    // Randomized traffic on both latencies
    keys[0].push_back(16'h0000); keys[0].push_back(16'h0040);
    keys[0].push_back(16'h0080); keys[0].push_back(16'h0100);
    rand_ops(0, 6);

    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      a = {4'h0, 8'($urandom), 4'h0};
      keys[1].push_back(a);
      txn(1, 1'b0, 1'b1, a, rand_blk());
    end
    rand_ops(1, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
